mem_dump: RTL and testbench

Synchronous readback engine for the CPU data memory: the reverse of program/data loading. On a start pulse it reads a run of consecutive 32-bit words from a synchronous single-port memory read port and streams them out MSB-first as bytes over a valid/ready interface. It sits beside the CPU's data memory, sharing its read port while the CPU is held or halted, and feeds a host-side byte sink (UART TX, trace FIFO) for post-run memory inspection.

---
 rtl/mem_dump.sv | 165 ++++++++++++++++
 tb/tb_mem_dump.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_dump.sv
// ---------------------------------------------------------------------------
// mem_dump
//
// Purpose:
//   Readback engine for the CPU data memory. A start pulse latches a base
//   word address and a word count. The engine reads that run of consecutive
//   32-bit words from a synchronous single-port memory read port. It streams
//   each word out MSB-first as four bytes over a valid/ready byte interface.
//   Its intended use is post-run memory inspection through a UART TX or a
//   trace FIFO, while the CPU is held off the data memory read port.
//
// Ports:
//   clock       : single clock, all logic on the rising edge
//   reset       : synchronous, active-high
//   start       : one-cycle request, only honoured while idle
//   base_addr   : first word address, latched on an accepted start
//   word_count  : number of words (0..2047), latched on an accepted start
//   mem_rd      : read strobe to memory (the only qualifier of mem_addr)
//   mem_addr    : word address to memory, holds its value between reads
//   mem_rdata   : read data, valid the cycle after mem_rd
//   out_data    : byte to the sink
//   out_valid   : out_data valid, never withdrawn before the handshake
//   out_ready   : sink accepts a byte when out_valid && out_ready
//   out_last    : marks the final byte of the final word
//   busy        : high while a transfer is in progress
//   done        : one-cycle completion pulse
// ---------------------------------------------------------------------------
module mem_dump #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_SEND,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   COUNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   COUNT_ZERO = '0;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W:0]     r_remaining;
  logic [DATA_W-1:0]   r_shift;
  logic [1:0]          r_byteIdx;

  logic [ADDR_W-1:0]   w_addrNext;
  logic [ADDR_W:0]     w_remainingNext;

  // The address counter wraps naturally at 2^ADDR_W, so a word count larger
  // than the memory simply repeats addresses.
  assign w_addrNext      = r_addr + ADDR_ONE;
  assign w_remainingNext = r_remaining - COUNT_ONE;

  // The whole engine is one registered FSM. Every output is a register that
  // is loaded on the transition into the state that owns it. This keeps the
  // outputs glitch-free and lets the first byte appear exactly three cycles
  // after the accepting edge: READ, then WAIT, then the first SEND cycle.
  // The shift register always holds the byte on out_data in its top byte.
  // Each handshake therefore loads out_data from the next byte down, at the
  // same time as the shift. After the fourth handshake the engine either
  // issues the next read directly or finishes.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_shift     <= '0;
      r_byteIdx   <= '0;
      mem_rd      <= 1'b0;
      mem_addr    <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_addr      <= base_addr;
            r_remaining <= word_count;
            if (word_count == COUNT_ZERO) begin
              r_state <= S_DONE;
              done    <= 1'b1;
            end else begin
              r_state  <= S_READ;
              mem_rd   <= 1'b1;
              mem_addr <= base_addr;
              busy     <= 1'b1;
            end
          end
        end

        S_READ: begin
          mem_rd  <= 1'b0;
          r_state <= S_WAIT;
        end

        S_WAIT: begin
          r_shift   <= mem_rdata;
          r_byteIdx <= 2'd0;
          out_data  <= mem_rdata[DATA_W-1 -: 8];
          out_valid <= 1'b1;
          out_last  <= 1'b0;
          r_state   <= S_SEND;
        end

        S_SEND: begin
          if (out_ready) begin
            if (r_byteIdx == 2'd3) begin
              r_remaining <= w_remainingNext;
              r_addr      <= w_addrNext;
              out_valid   <= 1'b0;
              out_last    <= 1'b0;
              if (w_remainingNext != COUNT_ZERO) begin
                r_state  <= S_READ;
                mem_rd   <= 1'b1;
                mem_addr <= w_addrNext;
              end else begin
                r_state <= S_DONE;
                busy    <= 1'b0;
                done    <= 1'b1;
              end
            end else begin
              r_shift   <= r_shift << 8;
              out_data  <= r_shift[DATA_W-9 -: 8];
              r_byteIdx <= r_byteIdx + 2'd1;
              out_last  <= (r_byteIdx == 2'd2) && (r_remaining == COUNT_ONE);
            end
          end
        end

        S_DONE: begin
          done    <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_dump.sv
// ---------------------------------------------------------------------------
// tb_mem_dump
//
// Purpose:
//   Self-checking bench for mem_dump. A behavioural memory answers the read
//   port. Each transfer is expanded up front from memory contents into the
//   word addresses and bytes it must produce. Independent monitors then
//   consume those expectations as the DUT presents reads, bytes and done.
// ---------------------------------------------------------------------------
module tb_mem_dump;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clock;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   word_count;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic [7:0]        out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              busy;
  logic              done;

  mem_dump #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done)
  );

  logic [31:0]       mem [DEPTH];
  logic [8:0]        byteQ [$];
  logic [ADDR_W-1:0] addrQ [$];

  int tests     = 0;
  int fails     = 0;
  int doneCount = 0;
  int rdCount   = 0;
  int readyMode = 0;

  logic       prevStall;
  logic [8:0] prevByte;
  logic [8:0] expByte;
  logic [ADDR_W-1:0] expAddr;

  // Free-running 100 MHz clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous single-port memory: data appears the cycle after the strobe.
  always @(posedge clock) begin
    if (mem_rd) mem_rdata <= mem[mem_addr];
  end

  // Sink readiness is changed just after each rising edge. Mode 0 holds
  // ready high, mode 1 is random, and mode 2 repeats the pattern 1,0,0.
  initial begin : readyDriver
    int phase;
    phase = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      case (readyMode)
        1:       out_ready = 1'($urandom_range(0, 1));
        2:       out_ready = (phase % 3 == 0);
        default: out_ready = 1'b1;
      endcase
      phase++;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // The monitor samples on the falling edge, away from the DUT's active edge.
  // Each read strobe consumes the next expected address. Each handshake
  // consumes the next expected byte. A stalled byte must be presented
  // unchanged on the following cycle. Every done pulse must find both
  // expectation queues empty.
  always @(negedge clock) begin
    if (reset) begin
      prevStall = 1'b0;
    end else begin
      if (mem_rd) begin
        rdCount++;
        if (addrQ.size() == 0) begin
          checkOutput("unexpected mem_rd", 64'(mem_addr), 64'hFFFF);
        end else begin
          expAddr = addrQ.pop_front();
          checkOutput("mem_addr", 64'(mem_addr), 64'(expAddr));
        end
      end
      if (prevStall) begin
        checkOutput("stall out_valid held", 64'(out_valid), 64'd1);
        checkOutput("stall byte held", 64'({out_last, out_data}), 64'(prevByte));
      end
      if (out_valid && out_ready) begin
        if (byteQ.size() == 0) begin
          checkOutput("unexpected byte", 64'({out_last, out_data}), 64'h1FFFF);
        end else begin
          expByte = byteQ.pop_front();
          checkOutput("byte {last,data}", 64'({out_last, out_data}), 64'(expByte));
        end
      end
      prevStall = out_valid && !out_ready;
      prevByte  = {out_last, out_data};
      if (done) begin
        doneCount++;
        checkOutput("bytes left at done", 64'(byteQ.size()), 64'd0);
        checkOutput("reads left at done", 64'(addrQ.size()), 64'd0);
      end
    end
  end

  // Turn a transfer request into the reads and bytes it must produce. Word w
  // lives at (base + w) mod DEPTH. Its bytes go out most-significant first.
  // The final byte of the final word carries the last flag.
  task automatic expectTransfer(input int base, input int count);
    logic [31:0] word;
    logic [7:0]  b;
    for (int w = 0; w < count; w++) begin
      addrQ.push_back(ADDR_W'((base + w) % DEPTH));
      word = mem[(base + w) % DEPTH];
      for (int k = 0; k < 4; k++) begin
        b = 8'((word >> (24 - 8 * k)) & 32'hFF);
        byteQ.push_back({(w == count - 1) && (k == 3), b});
      end
    end
  endtask

  // Run one complete transfer and check it. The request is pushed to the
  // scoreboard, start is pulsed, and the task waits a bounded time for done.
  // With ready held high the done latency is also checked. With extraStart
  // set, a conflicting start is raised mid-transfer and must be ignored.
  task automatic applyStimulus(input int base, input int count, input int mode,
                               input bit checkTiming, input bit extraStart);
    int cycles;
    int budget;
    int doneBefore;
    int rdBefore;
    bit seen;
    readyMode = mode;
    expectTransfer(base, count);
    doneBefore = doneCount;
    rdBefore   = rdCount;
    @(posedge clock);
    #1;
    base_addr  = ADDR_W'(base);
    word_count = (ADDR_W+1)'(count);
    start      = 1'b1;
    @(posedge clock);
    #1;
    start      = 1'b0;
    base_addr  = ADDR_W'($urandom);
    word_count = (ADDR_W+1)'($urandom);
    cycles = 0;
    seen   = 1'b0;
    budget = count * 60 + 20;
    while (!seen && cycles < budget) begin
      @(negedge clock);
      cycles++;
      if (cycles == 1)
        checkOutput("busy in first cycle", 64'(busy), 64'(count != 0));
      if (done) begin
        seen = 1'b1;
      end else if (extraStart && cycles == 3) begin
        base_addr  = 10'd500;
        word_count = 11'd5;
        start      = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    checkOutput("done seen within budget", 64'(seen), 64'd1);
    if (checkTiming)
      checkOutput("done latency", 64'(cycles), 64'(count == 0 ? 1 : 6 * count + 1));
    @(negedge clock);
    checkOutput("done pulse count", 64'(doneCount - doneBefore), 64'd1);
    checkOutput("mem_rd pulse count", 64'(rdCount - rdBefore), 64'(count));
    checkOutput("idle after done", 64'({busy, done, out_valid, mem_rd}), 64'd0);
    byteQ.delete();
    addrQ.delete();
  endtask

  initial begin : watchdog
    #3000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : mainSeq
    int doneBefore;
    int cycles;
    reset      = 1'b1;
    start      = 1'b0;
    base_addr  = '0;
    word_count = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'(i) * 32'h01010101;

    // Reset, then ten idle cycles in which every output must stay at zero.
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      checkOutput("idle outputs zero",
                  64'({mem_rd, mem_addr, out_data, out_valid, out_last, busy, done}), 64'd0);
    end

    $display("[TB] three-word readback with ready held high");
    applyStimulus(2, 3, 0, 1'b1, 1'b0);

    $display("[TB] single word with stalling sink");
    mem[4] = 32'h20100009;
    applyStimulus(4, 1, 2, 1'b0, 1'b0);

    $display("[TB] address wrap at top of memory");
    applyStimulus(1023, 2, 0, 1'b1, 1'b0);

    $display("[TB] zero-length transfer");
    applyStimulus(7, 0, 0, 1'b1, 1'b0);

    $display("[TB] start repeated while busy");
    applyStimulus(10, 2, 0, 1'b1, 1'b1);

    $display("[TB] reset during second word");
    readyMode = 0;
    expectTransfer(0, 3);
    doneBefore = doneCount;
    @(posedge clock);
    #1;
    base_addr  = 10'd0;
    word_count = 11'd3;
    start      = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    cycles = 0;
    while (cycles < 8) begin
      @(negedge clock);
      cycles++;
    end
    @(posedge clock);
    #1;
    checkOutput("sending before reset", 64'(out_valid), 64'd1);
    reset = 1'b1;
    @(posedge clock);
    #1;
    checkOutput("outputs after mid reset",
                64'({mem_rd, mem_addr, out_data, out_valid, out_last, busy, done}), 64'd0);
    reset = 1'b0;
    byteQ.delete();
    addrQ.delete();
    repeat (25) @(negedge clock);
    checkOutput("no done after reset", 64'(doneCount - doneBefore), 64'd0);

    $display("[TB] randomized transfers");
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    for (int t = 0; t < 20; t++) begin
      applyStimulus(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 6)),
                    (t % 2 == 0) ? 1 : 0, (t % 2 == 1), 1'b0);
    end

    $display("[TB] transfer longer than memory");
    applyStimulus(1000, 1030, 0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
